// File: rtl/pair_pkg.sv
// Shared types for the pair word <-> byte stream path: pair_t layout, unpacker states,
// and the byte-wide checksum helper used when the sum byte is enabled.
package pair_pkg;

    localparam int BYTE_W_DEF = 8;

    // .low occupies the MSBs of the packed word, .high the LSBs.
    typedef struct packed {
        logic [BYTE_W_DEF-1:0] low;
        logic [BYTE_W_DEF-1:0] high;
    } pair_t;

    typedef enum logic [1:0] {
        IDLE,
        EMIT0,
        EMIT1,
        EMITSUM
    } unpack_state_e;

    function automatic logic [BYTE_W_DEF-1:0] pair_sum(input pair_t p);
        return p.low + p.high;
    endfunction

endpackage

// File: rtl/pair_unpacker.sv
// Serializes one 2*BYTE_W pair word into bytes, out_last on the final byte; PAIR_UNPACK_SUM_EN adds a sum byte.
// Latency: word accepted at edge N, first byte valid in cycle N+1; 1 word / 2 cycles (3 with sum byte).
// Backpressure: out_ready low holds the current byte; in_ready only rises in IDLE or on the last byte's handshake.
module pair_unpacker
    import pair_pkg::*;
#(
    parameter int BYTE_W    = BYTE_W_DEF,
    parameter int CNT_W     = 16,
    parameter bit LOW_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2*BYTE_W-1:0] in_pair,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BYTE_W-1:0]   out_byte,
    output logic                out_last,
    output logic                busy,
    output logic [CNT_W-1:0]    word_count
);

    localparam int WORD_W = 2 * BYTE_W;

    unpack_state_e       state_q, state_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BYTE_W-1:0]   first_byte, second_byte;
    logic                last_state;
    logic                in_hs, out_hs;

    assign first_byte  = LOW_FIRST ? word_q[WORD_W-1:BYTE_W] : word_q[BYTE_W-1:0];
    assign second_byte = LOW_FIRST ? word_q[BYTE_W-1:0]      : word_q[WORD_W-1:BYTE_W];

`ifdef PAIR_UNPACK_SUM_EN
    logic [BYTE_W-1:0] sum_byte;
    assign sum_byte   = word_q[WORD_W-1:BYTE_W] + word_q[BYTE_W-1:0];
    assign last_state = (state_q == EMITSUM);
`else
    assign last_state = (state_q == EMIT1);
`endif

    // Depends on out_ready only, so a producer waiting on in_ready cannot form a loop.
    assign in_ready  = (state_q == IDLE) | (last_state & out_ready);
    assign out_valid = (state_q != IDLE);
    assign busy      = (state_q != IDLE);
    assign in_hs     = in_valid & in_ready;
    assign out_hs    = out_valid & out_ready;
    assign word_count = cnt_q;

    always_comb begin
        out_byte = '0;
        out_last = 1'b0;
        case (state_q)
            EMIT0: out_byte = first_byte;
            EMIT1: begin
                out_byte = second_byte;
`ifndef PAIR_UNPACK_SUM_EN
                out_last = 1'b1;
`endif
            end
`ifdef PAIR_UNPACK_SUM_EN
            EMITSUM: begin
                out_byte = sum_byte;
                out_last = 1'b1;
            end
`endif
            default: begin
                out_byte = '0;
                out_last = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        cnt_d   = cnt_q;
        if (in_hs) begin
            word_d = in_pair;
        end
        if (out_hs & out_last) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        case (state_q)
            IDLE:    if (in_valid)  state_d = EMIT0;
            EMIT0:   if (out_ready) state_d = EMIT1;
`ifdef PAIR_UNPACK_SUM_EN
            EMIT1:   if (out_ready) state_d = EMITSUM;
            EMITSUM: if (out_ready) state_d = in_valid ? EMIT0 : IDLE;
`else
            EMIT1:   if (out_ready) state_d = in_valid ? EMIT0 : IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            word_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pair_unpacker.sv
// Bench for pair_unpacker: directed vector table and corner sequences, then random traffic
// against a byte-queue reference model; a CNT_W=4 instance shares the stimulus for counter wrap.
module tb_pair_unpacker;

`ifdef PAIR_UNPACK_SUM_EN
    localparam bit SUM = 1'b1;
`else
    localparam bit SUM = 1'b0;
`endif
    localparam int NB = SUM ? 3 : 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_pair;
    logic        out_ready;
    logic        in_ready, out_valid, out_last, busy;
    logic [7:0]  out_byte;
    logic [15:0] word_count;
    logic        in_ready4, out_valid4, out_last4, busy4;
    logic [7:0]  out_byte4;
    logic [3:0]  wc4;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    pair_unpacker #(.BYTE_W(8), .CNT_W(16), .LOW_FIRST(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_pair(in_pair),
        .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte), .out_last(out_last),
        .busy(busy), .word_count(word_count)
    );

    pair_unpacker #(.BYTE_W(8), .CNT_W(4), .LOW_FIRST(1'b1)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4), .in_pair(in_pair),
        .out_valid(out_valid4), .out_ready(out_ready), .out_byte(out_byte4), .out_last(out_last4),
        .busy(busy4), .word_count(wc4)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Reference model: remaining bytes of the word in flight plus completed-word count.
    typedef struct { logic [7:0] b; bit last; } ob_t;
    ob_t exp_q[$];
    int  cnt = 0;

    function automatic void push_word(input logic [15:0] w);
        logic [7:0] lo, hi;
        lo = w[15:8];
        hi = w[7:0];
        exp_q.push_back('{lo, 1'b0});
        exp_q.push_back('{hi, !SUM});
        if (SUM) exp_q.push_back('{8'(lo + hi), 1'b1});
    endfunction

    always @(negedge clk) begin
        bit exp_rdy;
        if (!rst_n) begin
            chk("mon_rst_valid", {31'd0, out_valid}, 32'd0);
            exp_q.delete();
            cnt = 0;
        end else begin
            exp_rdy = (exp_q.size() == 0) || (exp_q.size() == 1 && out_ready);
            chk("mon_in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
            chk("mon_out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
            chk("mon_busy", {31'd0, busy}, {31'd0, exp_q.size() != 0});
            chk("mon_count", {16'd0, word_count}, {16'd0, cnt[15:0]});
            chk("mon_count4", {28'd0, wc4}, 32'(cnt % 16));
            chk("mon4_in_ready", {31'd0, in_ready4}, {31'd0, exp_rdy});
            chk("mon4_busy", {31'd0, busy4 & out_valid4}, {31'd0, exp_q.size() != 0});
            if (exp_q.size() != 0) begin
                chk("mon_byte", {24'd0, out_byte}, {24'd0, exp_q[0].b});
                chk("mon_last", {31'd0, out_last}, {31'd0, exp_q[0].last});
                chk("mon4_byte", {23'd0, out_last4, out_byte4}, {23'd0, exp_q[0].last, exp_q[0].b});
                if (out_ready) begin
                    if (exp_q[0].last) cnt++;
                    void'(exp_q.pop_front());
                end
            end
            if (in_valid && exp_rdy) push_word(in_pair);
        end
    end

    task automatic expect_out(input string nm, input logic [7:0] b, input logic l);
        @(negedge clk);
        chk({nm, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({nm, "_byte"}, {24'd0, out_byte}, {24'd0, b});
        chk({nm, "_last"}, {31'd0, out_last}, {31'd0, l});
    endtask

    task automatic send_word(input logic [15:0] w);
        int i;
        @(posedge clk); #1;
        in_valid = 1'b1; in_pair = w; out_ready = 1'b1;
        i = 0;
        @(negedge clk);
        while (!in_ready && i < 20) begin
            @(negedge clk);
            i++;
        end
        if (i >= 20) chk("send_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int i;
        in_valid = 1'b0; out_ready = 1'b1;
        i = 0;
        @(negedge clk);
        while (out_valid && i < 20) begin
            @(negedge clk);
            i++;
        end
        chk("drain_idle", {31'd0, out_valid}, 32'd0);
    endtask

    typedef struct { logic [15:0] word; logic [7:0] b0; logic [7:0] b1; logic [7:0] bs; } vec_t;
    vec_t vecs[6];

    initial begin
        logic acc;
        logic [7:0] eb [3];
        vecs[0] = '{16'hA55A, 8'hA5, 8'h5A, 8'hFF};
        vecs[1] = '{16'h1234, 8'h12, 8'h34, 8'h46};
        vecs[2] = '{16'hABCD, 8'hAB, 8'hCD, 8'h78};
        vecs[3] = '{16'hBEEF, 8'hBE, 8'hEF, 8'hAD};
        vecs[4] = '{16'hF00F, 8'hF0, 8'h0F, 8'hFF};
        vecs[5] = '{16'h8080, 8'h80, 8'h80, 8'h00};

        rst_n = 1'b0; in_valid = 1'b0; in_pair = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_byte", {24'd0, out_byte}, 32'd0);
        chk("rst_out_last", {31'd0, out_last}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_word_count", {16'd0, word_count}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Isolated words from the table.
        for (int v = 0; v < 6; v++) begin
            eb[0] = vecs[v].b0; eb[1] = vecs[v].b1; eb[2] = vecs[v].bs;
            @(posedge clk); #1;
            in_valid = 1'b1; in_pair = vecs[v].word; out_ready = 1'b1;
            @(negedge clk);
            chk("vec_in_ready", {31'd0, in_ready}, 32'd1);
            @(posedge clk); #1 in_valid = 1'b0;
            for (int k = 0; k < NB; k++) begin
                if (k > 0) begin @(posedge clk); #1; end
                expect_out("vec", eb[k], k == NB - 1);
            end
        end
        @(negedge clk);
        chk("vec_word_count", {16'd0, word_count}, 32'd6);

        // Back-to-back 1234 then ABCD without a bubble.
        @(posedge clk); #1;
        in_valid = 1'b1; in_pair = 16'h1234; out_ready = 1'b1;
        @(posedge clk); #1 in_pair = 16'hABCD;
        expect_out("b2b_12", 8'h12, 1'b0);
        chk("b2b_rdy_12", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        expect_out("b2b_34", 8'h34, !SUM);
        if (SUM) begin
            chk("b2b_rdy_34", {31'd0, in_ready}, 32'd0);
            @(posedge clk); #1;
            expect_out("b2b_s1", 8'h46, 1'b1);
        end
        chk("b2b_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1 in_valid = 1'b0;
        expect_out("b2b_AB", 8'hAB, 1'b0);
        @(posedge clk); #1;
        expect_out("b2b_CD", 8'hCD, !SUM);
        if (SUM) begin
            @(posedge clk); #1;
            expect_out("b2b_s2", 8'h78, 1'b1);
        end
        @(posedge clk); #1;

        // Stall on the first byte of BEEF.
        in_valid = 1'b1; in_pair = 16'hBEEF; out_ready = 1'b0;
        @(posedge clk); #1 in_valid = 1'b0;
        for (int s = 0; s < 3; s++) begin
            expect_out("stall_BE", 8'hBE, 1'b0);
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        expect_out("stall_BE_go", 8'hBE, 1'b0);
        @(posedge clk); #1;
        expect_out("stall_EF", 8'hEF, !SUM);
        drain();

        // Reset after the first byte of 1122.
        @(posedge clk); #1;
        in_valid = 1'b1; in_pair = 16'h1122; out_ready = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        expect_out("mid_11", 8'h11, 1'b0);
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_byte", {24'd0, out_byte}, 32'd0);
        chk("mid_rst_last", {31'd0, out_last}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_count", {16'd0, word_count}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("mid_no_22", {31'd0, out_valid}, 32'd0);
        end

        // Sixteen words: the 4-bit counter wraps to zero.
        for (int w = 0; w < 16; w++) send_word(16'(w * 16'h1111 + 16'h0102));
        drain();
        chk("wrap_count16", {16'd0, word_count}, 32'd16);
        chk("wrap_count4", {28'd0, wc4}, 32'd0);

        // Random traffic with a producer that holds until accepted.
        acc = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk); #1;
            if (!in_valid || acc) begin
                in_valid = 1'($urandom_range(0, 1));
                in_pair  = 16'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = in_valid && in_ready;
        end
        @(posedge clk); #1;
        drain();
        chk("final_count", {16'd0, word_count}, {16'd0, cnt[15:0]});
        chk("final_count4", {28'd0, wc4}, 32'(cnt % 16));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks passed %0d of %0d", n_pass, n_chk);
        $fatal(1);
    end

endmodule
